// File: rtl/memwb.sv
// Memory/writeback stage: non-memory results write back in the accept cycle (0 latency); loads/stores
// hold the stage in BUS until ack/err (>= 2 cycles); o_ready is low for the whole bus transaction.
module memwb #(
    parameter int RW    = 16,
    parameter int REGNO = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_submit,
    output logic             o_ready,
    input  logic [RW-1:0]    i_data,
    input  logic [RW-1:0]    i_addr,
    input  logic [REGNO-1:0] i_reg_ie,
    input  logic             i_mem_access,
    input  logic             i_mem_we,
    input  logic             i_mem_width,
    output logic [REGNO-1:0] o_reg_ie,
    output logic [RW-1:0]    o_reg_data,
    output logic             o_mem_req,
    output logic             o_mem_we,
    output logic [RW-1:0]    o_mem_addr,
    output logic [RW-1:0]    o_mem_data,
    output logic [1:0]       o_mem_sel,
    input  logic             i_mem_ack,
    input  logic [RW-1:0]    i_mem_data,
    input  logic             i_mem_err,
    output logic             o_mem_exception
);

    typedef enum logic {IDLE, BUS} state_t;

    state_t           state;
    logic [REGNO-1:0] lat_reg_ie;
    logic             lat_byte;
    logic             lat_a0;

    logic accept;
    logic bus_done_ok;

    assign o_ready     = (state == IDLE);
    assign accept      = i_submit && o_ready;
    assign bus_done_ok = (state == BUS) && o_mem_req && i_mem_ack && !i_mem_err;

    always_comb begin
        o_reg_ie   = '0;
        o_reg_data = '0;
        if (accept && !i_mem_access) begin
            o_reg_ie   = i_reg_ie;
            o_reg_data = i_data;
        end else if (bus_done_ok) begin
            // Stores latched a zero mask, so they never write the register file here.
            o_reg_ie = lat_reg_ie;
            if (!lat_byte)
                o_reg_data = i_mem_data;
            else if (lat_a0)
                o_reg_data = {{(RW-8){1'b0}}, i_mem_data[15:8]};
            else
                o_reg_data = {{(RW-8){1'b0}}, i_mem_data[7:0]};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state           <= IDLE;
            o_mem_req       <= 1'b0;
            o_mem_we        <= 1'b0;
            o_mem_addr      <= '0;
            o_mem_data      <= '0;
            o_mem_sel       <= 2'b00;
            o_mem_exception <= 1'b0;
            lat_reg_ie      <= '0;
            lat_byte        <= 1'b0;
            lat_a0          <= 1'b0;
        end else begin
            o_mem_exception <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept && i_mem_access) begin
                        state      <= BUS;
                        o_mem_req  <= 1'b1;
                        o_mem_we   <= i_mem_we;
                        lat_reg_ie <= i_mem_we ? '0 : i_reg_ie;
                        lat_byte   <= i_mem_width;
                        lat_a0     <= i_addr[0];
                        if (i_mem_width) begin
                            o_mem_addr <= {1'b0, i_addr[RW-1:1]};
                            o_mem_sel  <= i_addr[0] ? 2'b10 : 2'b01;
                            o_mem_data <= {(RW/8){i_data[7:0]}};
                        end else begin
                            o_mem_addr <= i_addr;
                            o_mem_sel  <= 2'b11;
                            o_mem_data <= i_data;
                        end
                    end
                end
                BUS: begin
                    if (o_mem_req && (i_mem_err || i_mem_ack)) begin
                        state     <= IDLE;
                        o_mem_req <= 1'b0;
                        o_mem_we  <= 1'b0;
                        // A fault wins over a simultaneous ack.
                        if (i_mem_err)
                            o_mem_exception <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memwb.sv
// Directed bench for memwb: stimulus pushes expected writebacks/bus requests, a negedge monitor checks them.
module tb_memwb;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_submit = 1'b0;
    logic        o_ready;
    logic [15:0] i_data = '0;
    logic [15:0] i_addr = '0;
    logic [7:0]  i_reg_ie = '0;
    logic        i_mem_access = 1'b0;
    logic        i_mem_we = 1'b0;
    logic        i_mem_width = 1'b0;
    logic [7:0]  o_reg_ie;
    logic [15:0] o_reg_data;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [15:0] o_mem_addr;
    logic [15:0] o_mem_data;
    logic [1:0]  o_mem_sel;
    logic        i_mem_ack = 1'b0;
    logic [15:0] i_mem_data = '0;
    logic        i_mem_err = 1'b0;
    logic        o_mem_exception;

    memwb #(.RW(16), .REGNO(8)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_submit(i_submit), .o_ready(o_ready),
        .i_data(i_data), .i_addr(i_addr), .i_reg_ie(i_reg_ie), .i_mem_access(i_mem_access),
        .i_mem_we(i_mem_we), .i_mem_width(i_mem_width), .o_reg_ie(o_reg_ie),
        .o_reg_data(o_reg_data), .o_mem_req(o_mem_req), .o_mem_we(o_mem_we),
        .o_mem_addr(o_mem_addr), .o_mem_data(o_mem_data), .o_mem_sel(o_mem_sel),
        .i_mem_ack(i_mem_ack), .i_mem_data(i_mem_data), .i_mem_err(i_mem_err),
        .o_mem_exception(o_mem_exception)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [7:0]  ie;
        logic [15:0] data;
    } wb_t;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
        logic [1:0]  sel;
        logic        we;
    } req_t;

    wb_t  wb_q[$];
    req_t req_q[$];
    req_t cur_req;
    int   exp_exc = 0;
    int   checks = 0;
    int   errors = 0;
    logic prev_req = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: compare every writeback, exception pulse and bus request against the queues.
    always @(negedge i_clk) begin
        if (i_rst_n) begin
            if (i_submit && !o_ready)
                $error("protocol violation: submit while stage busy");
            if (o_reg_ie != 8'h00) begin
                if (wb_q.size() == 0) begin
                    chk("wb_unexpected", {24'h0, o_reg_ie}, 32'h0);
                end else begin
                    wb_t e;
                    e = wb_q.pop_front();
                    chk("wb_ie", {24'h0, o_reg_ie}, {24'h0, e.ie});
                    chk("wb_data", {16'h0, o_reg_data}, {16'h0, e.data});
                end
            end
            if (o_mem_exception) begin
                chk("exc_expected", {31'h0, exp_exc > 0}, 32'h1);
                if (exp_exc > 0) exp_exc--;
            end
            if (o_mem_req && !prev_req) begin
                if (req_q.size() == 0) begin
                    chk("req_unexpected", {31'h0, o_mem_req}, 32'h0);
                end else begin
                    cur_req = req_q.pop_front();
                    chk("req_addr", {16'h0, o_mem_addr}, {16'h0, cur_req.addr});
                    chk("req_data", {16'h0, o_mem_data}, {16'h0, cur_req.data});
                    chk("req_sel", {30'h0, o_mem_sel}, {30'h0, cur_req.sel});
                    chk("req_we", {31'h0, o_mem_we}, {31'h0, cur_req.we});
                end
            end else if (o_mem_req) begin
                chk("req_hold", {o_mem_addr, o_mem_data}, {cur_req.addr, cur_req.data});
                chk("req_hold_ctl", {29'h0, o_mem_sel, o_mem_we}, {29'h0, cur_req.sel, cur_req.we});
            end
        end
        prev_req = o_mem_req;
    end

    task automatic cyc();
        @(posedge i_clk);
        #1;
    endtask

    task automatic submit(input logic mem, input logic we, input logic width,
                          input logic [15:0] data, input logic [15:0] addr, input logic [7:0] ie);
        i_submit = 1'b1; i_mem_access = mem; i_mem_we = we; i_mem_width = width;
        i_data = data; i_addr = addr; i_reg_ie = ie;
        cyc();
        i_submit = 1'b0; i_mem_access = 1'b0; i_mem_we = 1'b0; i_mem_width = 1'b0;
        i_reg_ie = 8'h00;
    endtask

    task automatic wait_req();
        int n = 0;
        while (!o_mem_req && n < 10) begin
            cyc();
            n++;
        end
        chk("req_seen", {31'h0, o_mem_req}, 32'h1);
        chk("ready_busy", {31'h0, o_ready}, 32'h0);
    endtask

    task automatic bus_ack(input int delay, input logic [15:0] rdata, input logic err);
        repeat (delay) cyc();
        i_mem_ack = 1'b1; i_mem_data = rdata; i_mem_err = err;
        cyc();
        i_mem_ack = 1'b0; i_mem_err = 1'b0; i_mem_data = 16'h0;
        chk("ready_after_bus", {31'h0, o_ready}, 32'h1);
        chk("req_dropped", {31'h0, o_mem_req}, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        #2;
        chk("rst_req", {31'h0, o_mem_req}, 32'h0);
        chk("rst_ready", {31'h0, o_ready}, 32'h1);
        chk("rst_exc", {31'h0, o_mem_exception}, 32'h0);
        chk("rst_addr", {16'h0, o_mem_addr}, 32'h0);
        cyc(); cyc();
        i_rst_n = 1'b1;
        cyc();

        // Non-memory back-to-back
        wb_q.push_back('{ie: 8'h04, data: 16'h1234});
        wb_q.push_back('{ie: 8'h40, data: 16'h5678});
        i_submit = 1'b1; i_data = 16'h1234; i_reg_ie = 8'h04;
        @(negedge i_clk);
        chk("nonmem_ready", {31'h0, o_ready}, 32'h1);
        cyc();
        i_data = 16'h5678; i_reg_ie = 8'h40;
        @(negedge i_clk);
        chk("nonmem_ready2", {31'h0, o_ready}, 32'h1);
        cyc();
        i_submit = 1'b0; i_reg_ie = 8'h00;
        cyc();

        // Word load, ack after 3 cycles
        req_q.push_back('{addr: 16'h0100, data: 16'h5555, sel: 2'b11, we: 1'b0});
        wb_q.push_back('{ie: 8'h02, data: 16'hBEEF});
        submit(1'b1, 1'b0, 1'b0, 16'h5555, 16'h0100, 8'h02);
        wait_req();
        bus_ack(3, 16'hBEEF, 1'b0);

        // Byte store, high lane: no writeback on ack
        req_q.push_back('{addr: 16'h0101, data: 16'hA5A5, sel: 2'b10, we: 1'b1});
        submit(1'b1, 1'b1, 1'b1, 16'h00A5, 16'h0203, 8'h10);
        wait_req();
        bus_ack(1, 16'hFFFF, 1'b0);

        // Byte loads, both lanes
        req_q.push_back('{addr: 16'h0008, data: 16'h0000, sel: 2'b01, we: 1'b0});
        wb_q.push_back('{ie: 8'h08, data: 16'h003C});
        submit(1'b1, 1'b0, 1'b1, 16'h0000, 16'h0010, 8'h08);
        wait_req();
        bus_ack(0, 16'h7F3C, 1'b0);
        req_q.push_back('{addr: 16'h0008, data: 16'h0000, sel: 2'b10, we: 1'b0});
        wb_q.push_back('{ie: 8'h80, data: 16'h007F});
        submit(1'b1, 1'b0, 1'b1, 16'h0000, 16'h0011, 8'h80);
        wait_req();
        bus_ack(2, 16'h7F3C, 1'b0);

        // Error with simultaneous ack: exception pulse, no writeback
        req_q.push_back('{addr: 16'h0300, data: 16'h0000, sel: 2'b11, we: 1'b0});
        exp_exc = 1;
        submit(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0300, 8'h01);
        wait_req();
        bus_ack(1, 16'hDEAD, 1'b1);
        chk("exc_pulse", {31'h0, o_mem_exception}, 32'h1);
        cyc();
        chk("exc_one_cycle", {31'h0, o_mem_exception}, 32'h0);

        // Reset mid-transaction
        req_q.push_back('{addr: 16'h0400, data: 16'h0000, sel: 2'b11, we: 1'b0});
        submit(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0400, 8'h20);
        wait_req();
        @(negedge i_clk);
        #2 i_rst_n = 1'b0;
        #1;
        chk("arst_req", {31'h0, o_mem_req}, 32'h0);
        chk("arst_ready", {31'h0, o_ready}, 32'h1);
        cyc();
        i_rst_n = 1'b1;
        repeat (3) begin
            cyc();
            chk("post_rst_exc", {31'h0, o_mem_exception}, 32'h0);
            chk("post_rst_req", {31'h0, o_mem_req}, 32'h0);
        end

        chk("wb_q_empty", wb_q.size(), 32'h0);
        chk("req_q_empty", req_q.size(), 32'h0);
        chk("exc_all_seen", exp_exc, 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/memwb.md
Name: memwb

Overview:
- Memory/writeback stage: final pipeline stage, directly after the execute stage.
- Accepts one committed instruction per handshake from execute: ALU result or address, store data, register write-enable mask, memory controls.
- Non-memory results are written back to the register file in the acceptance cycle. Loads and stores run a request/ack transaction on the data memory bus, writing back or raising a memory exception on completion.

Parameters:
RW, 16, data/address width in bits
REGNO, 8, number of architectural registers (width of one-hot write-enable mask)

Ports:
i_clk  input  1  clock
i_rst_n  input  1  asynchronous active-low reset
i_submit  input  1  instruction valid from execute (one-cycle pulse per instruction)
o_ready  output  1  stage can accept an instruction this cycle (to execute i_next_ready)
i_data  input  RW  ALU/sreg result, or store data when i_mem_access
i_addr  input  RW  memory address (byte-granular for byte access)
i_reg_ie  input  REGNO  one-hot destination register mask (0 = no writeback)
i_mem_access  input  1  instruction accesses memory
i_mem_we  input  1  1 = store, 0 = load
i_mem_width  input  1  1 = byte access, 0 = word access
o_reg_ie  output  REGNO  register file write-enable mask (combinational)
o_reg_data  output  RW  register file write data (combinational)
o_mem_req  output  1  bus request, held until ack or error
o_mem_we  output  1  bus write strobe
o_mem_addr  output  RW  bus word address
o_mem_data  output  RW  bus write data
o_mem_sel  output  2  byte-lane select, [1] = high byte
i_mem_ack  input  1  transaction complete; read data valid this cycle
i_mem_data  input  RW  bus read data
i_mem_err  input  1  bus/MMU fault, terminates transaction
o_mem_exception  output  1  one-cycle fault pulse to execute i_mem_exception

Behaviour:
- Single clock i_clk. Reset i_rst_n is asynchronous and active-low.
- Reset values:
  - state IDLE
  - o_mem_req, o_mem_we, o_mem_exception = 0
  - o_mem_addr, o_mem_data, o_mem_sel and latched reg mask/width/addr[0] = 0
  - o_ready = 1 (derived from state)
- FSM has two states: IDLE, BUS.
- o_ready = (state == IDLE). Purely state-derived; never depends on i_submit or bus inputs.
- Accept: i_submit & o_ready. i_submit while in BUS is a protocol violation and must be ignored (assertion in bench).
- IDLE, accepted, i_mem_access=0:
  - o_reg_ie = i_reg_ie and o_reg_data = i_data in the same cycle (zero latency).
  - State stays IDLE; back-to-back acceptance every cycle is allowed.
- IDLE, accepted, i_mem_access=1:
  - Register o_mem_req=1, o_mem_we=i_mem_we.
  - Latch i_reg_ie (forced to 0 for stores), width, i_addr[0].
  - Go to BUS. o_reg_ie = 0 in the accept cycle.
- Address/lane mapping, registered at acceptance:
  - Word access: o_mem_addr = i_addr, o_mem_sel = 2'b11, o_mem_data = i_data.
  - Byte access: o_mem_addr = {1'b0, i_addr[RW-1:1]}; o_mem_sel = i_addr[0] ? 2'b10 : 2'b01; o_mem_data = {i_data[7:0], i_data[7:0]}.
- BUS:
  - Hold all o_mem_* stable while o_mem_req=1.
  - Ack and err are sampled only while o_mem_req=1.
  - Ack without err:
    - Deassert o_mem_req next edge; go to IDLE.
    - For a load, in the ack cycle: o_reg_ie = latched mask. o_reg_data = i_mem_data for word; for byte, zero-extended lane selected by latched addr[0] (1 → [15:8], 0 → [7:0]).
  - Err (takes priority over a simultaneous ack):
    - No register write.
    - o_mem_exception = 1 for exactly the next cycle.
    - Deassert request; go to IDLE.
- o_reg_ie = 0 in every cycle not listed above.
- Latency:
  - Non-memory: 0 cycles.
  - Memory: request visible 1 cycle after accept; writeback in the ack cycle; o_ready high the cycle after ack/err.
  - Minimum 2-cycle occupancy per memory op.
- Reset asserted mid-transaction: o_mem_req drops asynchronously, no writeback, no exception pulse.

Test Plan:
- Reset release; IDLE; submit non-mem data=16'h1234, reg_ie=8'h04 → same cycle o_reg_ie=8'h04, o_reg_data=16'h1234, o_ready stays 1; second submit next cycle also accepted.
- Word load addr=16'h0100, reg_ie=8'h02 → next cycle o_mem_req=1, addr=16'h0100, sel=11, we=0, o_ready=0; ack after 3 cycles with i_mem_data=16'hBEEF → o_reg_ie=8'h02, o_reg_data=16'hBEEF in ack cycle; o_ready=1 next cycle.
- Byte store addr=16'h0203, data=16'h00A5 → o_mem_addr=16'h0101, sel=2'b10, o_mem_data=16'hA5A5, we=1; on ack o_reg_ie stays 0.
- Byte load addr=16'h0010, ack data=16'h7F3C → o_mem_addr=16'h0008, sel=01, o_reg_data=16'h003C; repeat with addr 16'h0011 → 16'h007F.
- Word load with i_mem_err and i_mem_ack both high → no writeback, o_mem_exception=1 for one cycle, o_mem_req=0, IDLE.
- Assert i_rst_n low while in BUS → o_mem_req=0 immediately, o_ready=1, no exception pulse after release.
